// File: rtl/gray_roundtrip_display_pkg.sv
// disp_pkg: shared types, blank pattern and hex glyph table for the
// Gray round-trip display block. Segment order is {g,f,e,d,c,b,a}, low = lit.
package disp_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Active-low one-hot anode enable for a digit slot.
  function automatic logic [3:0] digit_an(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/gray_roundtrip_display_hex7seg.sv
// hex7seg: combinational nibble -> active-low 7-segment glyph lookup.
module hex7seg
  import disp_pkg::*;
(
  input  nibble_t     i_nib,
  output logic [6:0]  o_seg
);

  // Straight table lookup; every nibble has a glyph.
  always_comb begin
    o_seg = HEX_SEG[i_nib];
  end

endmodule

// File: rtl/gray_roundtrip_display.sv
// gray_roundtrip_display: checks the decoded binary against the delayed
// reference, counts mismatches (saturating), and scans a 4-digit
// active-low 7-segment display showing {err_cnt, bin_ref, gray_in, bin_in}
// snapshots latched once per frame.
// Optional build macro: DISP_DP_HEARTBEAT_EN -- decimal point on digit 0
// blinks with a heartbeat that toggles every frame latch.
module gray_roundtrip_display
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int LAT         = 2
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bin_ref,
  input  logic [3:0]  gray_in,
  input  logic [3:0]  bin_in,
  input  logic        clr_err,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        err_led
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;
  digit_idx_t       r_idx;
  digit_idx_t       w_idx_next;
  logic             w_frame;

  nibble_t          r_snap_bin;
  nibble_t          r_snap_gray;
  nibble_t          r_snap_ref;
  nibble_t          r_snap_err;

  nibble_t          r_ref_sr [LAT];
  logic [LAT-1:0]   r_valid_sr;
  logic             w_mismatch;

  nibble_t          r_err_cnt;
  logic             r_err_led;

  nibble_t          w_digit_val;
  logic [6:0]       w_seg_pat;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  assign w_tick     = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign w_idx_next = r_idx + 2'd1;
  // The slot advancing from digit 3 back to digit 0 starts a new frame.
  assign w_frame    = w_tick && (r_idx == 2'd3);

  // Refresh divider: one tick per digit slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Digit scan index; resets to 3 so the first tick lands on digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= 2'd3;
    end else if (w_tick) begin
      r_idx <= w_idx_next;
    end
  end

  // Frame snapshot: all four digits of a frame come from the same instant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap_bin  <= '0;
      r_snap_gray <= '0;
      r_snap_ref  <= '0;
      r_snap_err  <= '0;
    end else if (w_frame) begin
      r_snap_bin  <= bin_in;
      r_snap_gray <= gray_in;
      r_snap_ref  <= bin_ref;
      r_snap_err  <= r_err_cnt;
    end
  end

  // Reference delay line matched to the encode/decode latency, plus a
  // validity line so nothing is compared until the pipe has filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_ref_sr[i] <= '0;
      end
      r_valid_sr <= '0;
    end else begin
      r_ref_sr[0]   <= bin_ref;
      r_valid_sr[0] <= 1'b1;
      for (int i = 1; i < LAT; i++) begin
        r_ref_sr[i]   <= r_ref_sr[i-1];
        r_valid_sr[i] <= r_valid_sr[i-1];
      end
    end
  end

  assign w_mismatch = r_valid_sr[LAT-1] && (r_ref_sr[LAT-1] != bin_in);

  // Saturating error counter and sticky LED; a clear beats a same-cycle mismatch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
      r_err_led <= 1'b0;
    end else if (clr_err) begin
      r_err_cnt <= '0;
      r_err_led <= 1'b0;
    end else if (w_mismatch) begin
      r_err_led <= 1'b1;
      if (r_err_cnt != 4'hF) begin
        r_err_cnt <= r_err_cnt + 4'd1;
      end
    end
  end

  assign err_led = r_err_led;

  // Value for the slot about to be shown. Digit 0 is loaded on the same edge
  // the snapshot is taken, so it bypasses to the live input on that edge.
  always_comb begin
    w_digit_val = '0;
    case (w_idx_next)
      2'd0:    w_digit_val = w_frame ? bin_in : r_snap_bin;
      2'd1:    w_digit_val = r_snap_gray;
      2'd2:    w_digit_val = r_snap_ref;
      default: w_digit_val = r_snap_err;
    endcase
  end

  hex7seg u_hex7seg (
    .i_nib (w_digit_val),
    .o_seg (w_seg_pat)
  );

  // Registered anode/segment drive, updated once per slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else if (w_tick) begin
      r_an  <= digit_an(w_idx_next);
      r_seg <= w_seg_pat;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

`ifdef DISP_DP_HEARTBEAT_EN
  logic r_hb;
  logic w_hb_next;
  logic r_dp;

  assign w_hb_next = w_frame ? ~r_hb : r_hb;

  // Heartbeat flips every frame and is shown on digit 0's decimal point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hb <= 1'b0;
      r_dp <= 1'b1;
    end else begin
      r_hb <= w_hb_next;
      if (w_tick) begin
        r_dp <= (w_idx_next == 2'd0) ? ~w_hb_next : 1'b1;
      end
    end
  end

  assign dp = r_dp;
`else
  assign dp = 1'b1;
`endif

endmodule
